// File: rtl/relu_buffer_floating_point32.sv
// relu_buffer_floating_point32
//
// Takes the serial stream of node sums from the float32 adder. The input is
// valid-only and has no backpressure. The block applies ReLU to each sum as it
// is written, collects one layer vector of NUM_NODES activations, then drains
// that vector to the next layer over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-high (asserted = 1)
//   i_valid    adder sum valid, one sum per cycle while high
//   i_data     adder sum, IEEE-754 single
//   i_ready    next layer accepts o_data this cycle
//   o_valid    o_data holds an activation (registered)
//   o_data     ReLU'd activation (registered)
//   o_last     marks the final element of the vector (registered)
//   o_overflow one-cycle pulse: an input sample arrived while draining and was dropped
module relu_buffer_floating_point32 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_NODES  = 3,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_overflow
);

    if (DATA_WIDTH != 32 || NUM_NODES < 2 || NUM_NODES > 16 ||
        (2 ** ADDR_WIDTH) < NUM_NODES) begin : gen_param_check
        $error("relu_buffer_floating_point32: unsupported parameter set");
    end

    typedef enum logic [0:0] {StCollect, StDrain} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_NODES - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_next;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_NODES];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   relu_data;
    logic                    xfer;
    logic                    final_xfer;

    // A set sign bit zeroes the word. This covers -0, -inf and sign-set NaN.
    assign relu_data  = i_data[DATA_WIDTH-1] ? '0 : i_data;
    assign xfer       = (state_q == StDrain) && i_ready;
    assign final_xfer = xfer && last_q;
    assign rd_next    = rd_ptr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        last_d   = last_q;
        ovf_d    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;

        unique case (state_q)
            StCollect: begin
                if (i_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LastIdx) begin
                        // Slot 0 was written on an earlier cycle, so the first
                        // output word can be preloaded on this same edge.
                        state_d  = StDrain;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        data_d   = mem_q[0];
                        last_d   = 1'b0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d  = StCollect;
                        rd_ptr_d = '0;
                        data_d   = '0;
                        last_d   = 1'b0;
                        // A sum arriving on the final handshake starts the next vector.
                        if (i_valid) begin
                            wr_en    = 1'b1;
                            wr_addr  = '0;
                            wr_ptr_d = ADDR_WIDTH'(1);
                        end
                    end else begin
                        rd_ptr_d = rd_next;
                        data_d   = mem_q[rd_next];
                        last_d   = (rd_next == LastIdx);
                    end
                end
                if (i_valid && !final_xfer) begin
                    ovf_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= StCollect;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= relu_data;
        end
    end

    assign o_valid    = (state_q == StDrain);
    assign o_data     = data_q;
    assign o_last     = last_q;
    assign o_overflow = ovf_q;

endmodule
